// File: rtl/psum_accum_act_if.sv
// Handshake bundle for psum_accum_act.
// Ports: input beat (in_valid, in_psum, bias) and
//   output FIFO head (out_valid, out_ready, out_data).
//   master = producer/consumer side, slave = accumulator side.
interface psum_accum_act_if #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_psum;
    logic [ACC_W-1:0] bias;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_psum, bias, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_psum, bias, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/psum_accum_act.sv
// Partial-sum accumulator: bias add, ReLU, shift, saturate, output FIFO.
// Ports: clk, rst (sync, active high), clr (drop partial neuron),
//   bus (psum_accum_act_if.slave), busy (mid-neuron), ovf_err (sticky drop).
// Option: PSUM_ACC_ROUND_EN selects round-half-up instead of truncating shift.
module psum_accum_act #(
    parameter int IN_W       = 9,
    parameter int ACC_W      = 16,
    parameter int CHUNK_CNT  = 4,
    parameter int SHIFT      = 2,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    psum_accum_act_if.slave   bus,
    output logic              busy,
    output logic              ovf_err
);
    localparam int CW = (CHUNK_CNT > 1) ? $clog2(CHUNK_CNT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNK_CNT - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
    localparam logic [ACC_W-1:0] MAXV =
        {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [NW-1:0]    count;
    logic [OUT_W-1:0] head_data;

    logic             first;
    logic             last;
    logic             push;
    logic             pop;
    logic             full;
    logic             take;
    logic             drop;
    logic [ACC_W-1:0] psum_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] shifted;
    logic [OUT_W-1:0] act;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A beat arriving with clr starts a fresh neuron, so it takes the bias.
    assign psum_ext = ACC_W'(bus.in_psum);
    assign first    = clr || (state == IDLE);
    assign sum      = (first ? bus.bias : acc) + psum_ext;
    assign last     = first ? (CHUNK_CNT == 1) : (cnt == LAST_CNT);

`ifdef PSUM_ACC_ROUND_EN
    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic [ACC_W:0] HALF_W =
        ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
    assign shifted = (sum + HALF_W[ACC_W-1:0]) >> SHIFT;
`else
    assign shifted = sum >> SHIFT;
`endif

    assign act = sum[ACC_W-1]    ? '0 :
                 (shifted > MAXV) ? '1 :
                 shifted[OUT_W-1:0];

    assign push = bus.in_valid && last;
    assign pop  = bus.out_valid && bus.out_ready;
    assign full = (count == FULL_CNT);
    assign take = push && (!full || pop);
    assign drop = push && full && !pop;

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = head_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
        end else if (bus.in_valid) begin
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                state <= ACCUM;
                acc   <= sum;
                cnt   <= first ? CW'(1) : cnt + 1'b1;
                busy  <= 1'b1;
            end
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem[wr_ptr] <= act;
        end
    end

    // head_data is the registered FIFO head; it keeps its value when
    // the FIFO drains so out_data stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (take) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (take && !pop) begin
                count <= count + 1'b1;
            end else if (!take && pop) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
            if (pop) begin
                if (count != NW'(1)) begin
                    head_data <= mem[nxt(rd_ptr)];
                end else if (take) begin
                    head_data <= act;
                end
            end else if (take && count == '0) begin
                head_data <= act;
            end
        end
    end
endmodule
